// File: rtl/ssd_mem_pkg.sv
// Shared command layout, FSM states and beat arithmetic for the clk150 memory responder.
// Command word is {len[12:0], byte_addr[31:0]}; one beat is one 32-bit memory word.
package ssd_mem_pkg;

    localparam int CMD_LEN_W  = 13;
    localparam int CMD_ADDR_W = 32;
    localparam int CMD_W      = CMD_LEN_W + CMD_ADDR_W;
    localparam int BEATS_W    = 12;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_BURST = 2'd2
    } state_t;

    function automatic logic [CMD_LEN_W-1:0] cmd_len_f(input logic [CMD_W-1:0] cmd);
        return cmd[CMD_W-1:CMD_ADDR_W];
    endfunction

    function automatic logic [CMD_ADDR_W-1:0] cmd_addr_f(input logic [CMD_W-1:0] cmd);
        return cmd[CMD_ADDR_W-1:0];
    endfunction

    // Round the byte length up to whole words: (len + 3) >> 2.
    function automatic logic [BEATS_W-1:0] beats_f(input logic [CMD_LEN_W-1:0] len);
        logic [CMD_LEN_W:0] sum;
        sum = {1'b0, len} + (CMD_LEN_W+1)'(3);
        return sum[CMD_LEN_W:2];
    endfunction

endpackage

// File: rtl/ssd_rd_fifo.sv
// Read-return FWFT FIFO: push is written next cycle, head word is visible while not empty.
// No internal backpressure on push; the caller's credit scheme keeps it from overflowing.
module ssd_rd_fifo #(
    parameter int DEPTH = 16,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DW-1:0]            push_data,
    input  logic                     pop,
    output logic [DW-1:0]            pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (AW+1)'(1);
            end else if (!do_push && do_pop) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/ssd_mem_cmd_responder.sv
// Splits read/write commands into per-word memory accesses; reads return through a credited FWFT buffer.
// Command ready is combinational in IDLE only; read issue stalls when buffer plus in-flight reads reach depth.
module ssd_mem_cmd_responder
    import ssd_mem_pkg::*;
#(
    parameter int LEN_W         = 13,
    parameter int ADDR_W        = 32,
    parameter int RD_FIFO_DEPTH = 16,
    parameter int MEM_AW        = 30
) (
    input  logic                     clk150,
    input  logic                     nReset150,
    input  logic [LEN_W+ADDR_W-1:0]  clk150_cmd_dramWrData_data,
    input  logic                     clk150_cmd_dramWrData_valid,
    output logic                     clk150_cmd_dramWrData_ready,
    input  logic [LEN_W+ADDR_W-1:0]  clk150_cmd_dramRdData_data,
    input  logic                     clk150_cmd_dramRdData_valid,
    output logic                     clk150_cmd_dramRdData_ready,
    input  logic [31:0]              clk150_dramWrData_data,
    input  logic                     clk150_dramWrData_valid,
    output logic                     clk150_dramWrData_ready,
    output logic [31:0]              clk150_dramRdData_data,
    output logic                     clk150_dramRdData_valid,
    input  logic                     clk150_dramRdData_ready,
    output logic [MEM_AW-1:0]        mem_addr,
    output logic                     mem_wr_en,
    output logic [31:0]              mem_wdata,
    output logic                     mem_rd_en,
    input  logic                     mem_ready,
    input  logic [31:0]              mem_rdata,
    input  logic                     mem_rdata_valid
);
    localparam int OW = $clog2(RD_FIFO_DEPTH) + 1;

    state_t              state;
    logic                run;
    logic                last_rd;
    logic [MEM_AW-1:0]   addr;
    logic [BEATS_W-1:0]  remaining;
    logic [OW-1:0]       outstanding;

    logic                in_idle;
    logic                in_wr;
    logic                in_rd;
    logic                wr_grant;
    logic                rd_grant;
    logic                cmd_accept;
    logic [CMD_W-1:0]    sel_cmd;
    logic [ADDR_W-1:0]   sel_addr;
    logic [BEATS_W-1:0]  sel_beats;
    logic [1:0]          byte_ofs_unused;
    logic                credit;
    logic                wr_beat;
    logic                rd_issue;
    logic                fifo_full;
    logic                fifo_empty;
    logic [OW-1:0]       fifo_count;

    // run holds command ready low while reset is asserted, keeping every output at zero.
    assign in_idle = run && (state == IDLE);
    assign in_wr   = (state == WR_BURST);
    assign in_rd   = (state == RD_BURST);

    // Round-robin: when both are pending, the type not served last wins.
    assign wr_grant   = in_idle && clk150_cmd_dramWrData_valid && (!clk150_cmd_dramRdData_valid || last_rd);
    assign rd_grant   = in_idle && clk150_cmd_dramRdData_valid && (!clk150_cmd_dramWrData_valid || !last_rd);
    assign cmd_accept = wr_grant || rd_grant;

    assign clk150_cmd_dramWrData_ready = wr_grant;
    assign clk150_cmd_dramRdData_ready = rd_grant;

    assign sel_cmd         = wr_grant ? clk150_cmd_dramWrData_data : clk150_cmd_dramRdData_data;
    assign sel_addr        = cmd_addr_f(sel_cmd);
    assign sel_beats       = beats_f(cmd_len_f(sel_cmd));
    assign byte_ofs_unused = sel_addr[1:0];

    assign credit   = ({1'b0, fifo_count} + {1'b0, outstanding}) < (OW+1)'(RD_FIFO_DEPTH);
    assign wr_beat  = in_wr && clk150_dramWrData_valid && mem_ready;
    assign rd_issue = in_rd && credit && mem_ready;

    assign clk150_dramWrData_ready = in_wr && mem_ready;
    assign mem_wr_en               = in_wr && clk150_dramWrData_valid;
    assign mem_wdata               = in_wr ? clk150_dramWrData_data : '0;
    assign mem_rd_en               = in_rd && credit;
    assign mem_addr                = addr;

    always_ff @(posedge clk150 or negedge nReset150) begin
        if (!nReset150) begin
            state       <= IDLE;
            run         <= 1'b0;
            last_rd     <= 1'b1;
            addr        <= '0;
            remaining   <= '0;
            outstanding <= '0;
        end else begin
            run <= 1'b1;

            if (rd_issue && !mem_rdata_valid) begin
                outstanding <= outstanding + OW'(1);
            end else if (!rd_issue && mem_rdata_valid) begin
                outstanding <= outstanding - OW'(1);
            end

            case (state)
                IDLE: begin
                    if (cmd_accept) begin
                        last_rd   <= rd_grant;
                        addr      <= sel_addr[MEM_AW+1:2];
                        remaining <= sel_beats;
                        if (sel_beats != '0) begin
                            state <= wr_grant ? WR_BURST : RD_BURST;
                        end
                    end
                end
                WR_BURST: begin
                    if (wr_beat) begin
                        addr      <= addr + MEM_AW'(1);
                        remaining <= remaining - BEATS_W'(1);
                        if (remaining == BEATS_W'(1)) begin
                            state <= IDLE;
                        end
                    end
                end
                RD_BURST: begin
                    if (rd_issue) begin
                        addr      <= addr + MEM_AW'(1);
                        remaining <= remaining - BEATS_W'(1);
                        if (remaining == BEATS_W'(1)) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    ssd_rd_fifo #(
        .DEPTH (RD_FIFO_DEPTH),
        .DW    (32)
    ) u_rd_fifo (
        .clk       (clk150),
        .rst_n     (nReset150),
        .push      (mem_rdata_valid),
        .push_data (mem_rdata),
        .pop       (clk150_dramRdData_valid && clk150_dramRdData_ready),
        .pop_data  (clk150_dramRdData_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign clk150_dramRdData_valid = !fifo_empty;

endmodule

// File: tb/tb_ssd_mem_cmd_responder.sv
// Directed bench for ssd_mem_cmd_responder with a fixed-latency (3 cycle) memory model.
module tb_ssd_mem_cmd_responder;

    localparam int LAT = 3;

    logic        clk150 = 1'b0;
    logic        nReset150;
    logic [44:0] clk150_cmd_dramWrData_data;
    logic        clk150_cmd_dramWrData_valid;
    logic        clk150_cmd_dramWrData_ready;
    logic [44:0] clk150_cmd_dramRdData_data;
    logic        clk150_cmd_dramRdData_valid;
    logic        clk150_cmd_dramRdData_ready;
    logic [31:0] clk150_dramWrData_data;
    logic        clk150_dramWrData_valid;
    logic        clk150_dramWrData_ready;
    logic [31:0] clk150_dramRdData_data;
    logic        clk150_dramRdData_valid;
    logic        clk150_dramRdData_ready;
    logic [29:0] mem_addr;
    logic        mem_wr_en;
    logic [31:0] mem_wdata;
    logic        mem_rd_en;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_rdata_valid;

    int errs   = 0;
    int checks = 0;

    logic [31:0] wq_a[$];
    logic [31:0] wq_d[$];
    logic [31:0] rq_a[$];
    logic [31:0] oq[$];
    int          gq[$];

    logic        pv [LAT];
    logic [31:0] pd [LAT];

    ssd_mem_cmd_responder dut (
        .clk150                      (clk150),
        .nReset150                   (nReset150),
        .clk150_cmd_dramWrData_data  (clk150_cmd_dramWrData_data),
        .clk150_cmd_dramWrData_valid (clk150_cmd_dramWrData_valid),
        .clk150_cmd_dramWrData_ready (clk150_cmd_dramWrData_ready),
        .clk150_cmd_dramRdData_data  (clk150_cmd_dramRdData_data),
        .clk150_cmd_dramRdData_valid (clk150_cmd_dramRdData_valid),
        .clk150_cmd_dramRdData_ready (clk150_cmd_dramRdData_ready),
        .clk150_dramWrData_data      (clk150_dramWrData_data),
        .clk150_dramWrData_valid     (clk150_dramWrData_valid),
        .clk150_dramWrData_ready     (clk150_dramWrData_ready),
        .clk150_dramRdData_data      (clk150_dramRdData_data),
        .clk150_dramRdData_valid     (clk150_dramRdData_valid),
        .clk150_dramRdData_ready     (clk150_dramRdData_ready),
        .mem_addr                    (mem_addr),
        .mem_wr_en                   (mem_wr_en),
        .mem_wdata                   (mem_wdata),
        .mem_rd_en                   (mem_rd_en),
        .mem_ready                   (mem_ready),
        .mem_rdata                   (mem_rdata),
        .mem_rdata_valid             (mem_rdata_valid)
    );

    always #5 clk150 = ~clk150;

    // Memory: every accepted read returns {2'b10, word_addr} three cycles later; cleared by reset.
    always @(posedge clk150) begin
        logic        fire;
        logic [31:0] a;
        fire = mem_rd_en && mem_ready;
        a    = {2'b10, mem_addr};
        #1;
        if (!nReset150) begin
            for (int i = 0; i < LAT; i++) begin
                pv[i] = 1'b0;
                pd[i] = '0;
            end
        end else begin
            for (int i = LAT-1; i > 0; i--) begin
                pv[i] = pv[i-1];
                pd[i] = pd[i-1];
            end
            pv[0] = fire;
            pd[0] = a;
        end
        mem_rdata_valid = pv[LAT-1];
        mem_rdata       = pd[LAT-1];
    end

    always @(posedge clk150) begin
        if (nReset150) begin
            if (mem_wr_en && mem_ready) begin
                wq_a.push_back({2'b00, mem_addr});
                wq_d.push_back(mem_wdata);
            end
            if (mem_rd_en && mem_ready) rq_a.push_back({2'b00, mem_addr});
            if (clk150_dramRdData_valid && clk150_dramRdData_ready) oq.push_back(clk150_dramRdData_data);
            if (clk150_cmd_dramWrData_valid && clk150_cmd_dramWrData_ready) gq.push_back(1);
            if (clk150_cmd_dramRdData_valid && clk150_cmd_dramRdData_ready) gq.push_back(2);
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        wq_a.delete(); wq_d.delete(); rq_a.delete(); oq.delete(); gq.delete();
    endtask

    // kind 0 = write command, 1 = read command, 2 = write data. Called at a falling edge.
    task automatic xfer(input string tag, input int kind, input logic [44:0] dat);
        int   n;
        logic rdy;
        n = 0;
        case (kind)
            0: begin clk150_cmd_dramWrData_data = dat; clk150_cmd_dramWrData_valid = 1'b1; end
            1: begin clk150_cmd_dramRdData_data = dat; clk150_cmd_dramRdData_valid = 1'b1; end
            default: begin clk150_dramWrData_data = dat[31:0]; clk150_dramWrData_valid = 1'b1; end
        endcase
        #1;
        rdy = (kind == 0) ? clk150_cmd_dramWrData_ready :
              (kind == 1) ? clk150_cmd_dramRdData_ready : clk150_dramWrData_ready;
        while (!rdy && n < 100) begin
            @(negedge clk150); #1; n++;
            rdy = (kind == 0) ? clk150_cmd_dramWrData_ready :
                  (kind == 1) ? clk150_cmd_dramRdData_ready : clk150_dramWrData_ready;
        end
        check_eq(tag, n < 100, 1);
        @(posedge clk150);
        @(negedge clk150);
        clk150_cmd_dramWrData_valid = 1'b0;
        clk150_cmd_dramRdData_valid = 1'b0;
        clk150_dramWrData_valid     = 1'b0;
    endtask

    task automatic wait_out(input string tag, input int want, input int budget);
        int n;
        n = 0;
        while (oq.size() < want && n < budget) begin
            @(negedge clk150); n++;
        end
        check_eq(tag, n < budget, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
        $fatal(1);
    end

    initial begin
        int bad;
        nReset150                   = 1'b0;
        clk150_cmd_dramWrData_data  = {13'd16, 32'h0};
        clk150_cmd_dramWrData_valid = 1'b1;
        clk150_cmd_dramRdData_data  = {13'd16, 32'h0};
        clk150_cmd_dramRdData_valid = 1'b1;
        clk150_dramWrData_data      = 32'hFFFF_FFFF;
        clk150_dramWrData_valid     = 1'b1;
        clk150_dramRdData_ready     = 1'b1;
        mem_ready                   = 1'b1;
        mem_rdata                   = '0;
        mem_rdata_valid             = 1'b0;

        repeat (3) @(negedge clk150);
        #1;
        check_eq("rst_wr_cmd_ready", clk150_cmd_dramWrData_ready, 0);
        check_eq("rst_rd_cmd_ready", clk150_cmd_dramRdData_ready, 0);
        check_eq("rst_wdata_ready", clk150_dramWrData_ready, 0);
        check_eq("rst_mem_en", {mem_wr_en, mem_rd_en, clk150_dramRdData_valid}, 0);
        check_eq("rst_mem_addr_wdata", {mem_addr, mem_wdata, clk150_dramRdData_data}, 0);

        @(negedge clk150);
        clk150_cmd_dramWrData_valid = 1'b0;
        clk150_cmd_dramRdData_valid = 1'b0;
        clk150_dramWrData_valid     = 1'b0;
        nReset150                   = 1'b1;
        repeat (2) @(negedge clk150);

        // Write burst: len 16 at 0x100 -> words 0x40..0x43.
        clear_logs();
        xfer("wr_cmd_accept", 0, {13'd16, 32'h100});
        for (int i = 0; i < 4; i++) xfer("wr_data_accept", 2, {13'd0, 32'hA0 + 32'(i)});
        check_eq("wr_beats", wq_a.size(), 4);
        for (int i = 0; i < 4 && i < wq_a.size(); i++) begin
            check_eq("wr_addr", wq_a[i], 32'h40 + 32'(i));
            check_eq("wr_data", wq_d[i], 32'hA0 + 32'(i));
        end
        clk150_cmd_dramWrData_data  = {13'd0, 32'h500};
        clk150_cmd_dramWrData_valid = 1'b1;
        #1;
        check_eq("wr_idle_next_cycle", clk150_cmd_dramWrData_ready, 1);
        @(posedge clk150);
        @(negedge clk150);
        clk150_cmd_dramWrData_valid = 1'b0;
        clk150_cmd_dramRdData_data  = {13'd0, 32'h600};
        clk150_cmd_dramRdData_valid = 1'b1;
        #1;
        check_eq("len0_one_cycle", clk150_cmd_dramRdData_ready, 1);
        @(posedge clk150);
        @(negedge clk150);
        clk150_cmd_dramRdData_valid = 1'b0;
        clk150_dramWrData_valid     = 1'b1;
        #1;
        check_eq("wdata_idle_not_ready", {clk150_dramWrData_ready, mem_wr_en}, 0);
        @(negedge clk150);
        clk150_dramWrData_valid = 1'b0;
        repeat (3) @(negedge clk150);
        check_eq("len0_no_access", {wq_a.size(), rq_a.size()}, {32'd4, 32'd0});

        // Read len 6 at 0x200 -> 2 words at 0x80, 0x81.
        clear_logs();
        xfer("rd_cmd_accept", 1, {13'd6, 32'h200});
        wait_out("rd_short_done", 2, 100);
        check_eq("rd_short_reqs", rq_a.size(), 2);
        if (rq_a.size() == 2) begin
            check_eq("rd_addr0", rq_a[0], 32'h80);
            check_eq("rd_addr1", rq_a[1], 32'h81);
        end
        if (oq.size() >= 2) begin
            check_eq("rd_data0", oq[0], 32'h8000_0080);
            check_eq("rd_data1", oq[1], 32'h8000_0081);
        end
        repeat (5) @(negedge clk150);

        // Long read with downstream stalled: credit caps issue at 16.
        clear_logs();
        clk150_dramRdData_ready = 1'b0;
        xfer("rd_long_accept", 1, {13'd256, 32'h1000});
        repeat (40) @(negedge clk150);
        #1;
        check_eq("credit_stall_reqs", rq_a.size(), 16);
        check_eq("credit_stall_head", {clk150_dramRdData_valid, clk150_dramRdData_data}, {1'b1, 32'h8000_0400});
        @(negedge clk150);
        clk150_dramRdData_ready = 1'b1;
        wait_out("rd_long_drain", 64, 1000);
        repeat (5) @(negedge clk150);
        check_eq("rd_long_reqs", rq_a.size(), 64);
        check_eq("rd_long_words", oq.size(), 64);
        bad = 0;
        for (int i = 0; i < oq.size(); i++) if (oq[i] !== 32'h8000_0400 + 32'(i)) bad++;
        check_eq("rd_long_order", bad, 0);

        // Arbitration with both command types pending every cycle.
        clear_logs();
        clk150_cmd_dramWrData_data  = {13'd0, 32'h0};
        clk150_cmd_dramRdData_data  = {13'd0, 32'h0};
        clk150_cmd_dramWrData_valid = 1'b1;
        clk150_cmd_dramRdData_valid = 1'b1;
        repeat (6) @(negedge clk150);
        clk150_cmd_dramWrData_valid = 1'b0;
        clk150_cmd_dramRdData_valid = 1'b0;
        check_eq("rr_grants", gq.size(), 6);
        bad = 0;
        for (int i = 0; i < gq.size(); i++) if (gq[i] != ((i % 2 == 0) ? 1 : 2)) bad++;
        check_eq("rr_alternate", bad, 0);
        check_eq("rr_no_access", wq_a.size() + rq_a.size(), 0);
        repeat (2) @(negedge clk150);

        // Random handshakes then reset in the middle of a 32-beat read.
        clear_logs();
        xfer("rd_rand_accept", 1, {13'd128, 32'h3000});
        for (int i = 0; i < 12; i++) begin
            mem_ready               = 1'($urandom_range(0, 1));
            clk150_dramRdData_ready = 1'($urandom_range(0, 1));
            @(negedge clk150);
        end
        check_eq("rand_mid_burst", (rq_a.size() < 32), 1);
        bad = 0;
        for (int i = 0; i < oq.size(); i++) if (oq[i] !== 32'h8000_0C00 + 32'(i)) bad++;
        check_eq("rand_order", bad, 0);
        nReset150                   = 1'b0;
        clk150_cmd_dramWrData_valid = 1'b1;
        mem_ready                   = 1'b1;
        #1;
        check_eq("midrst_cmd_ready", {clk150_cmd_dramWrData_ready, clk150_cmd_dramRdData_ready}, 0);
        check_eq("midrst_mem", {mem_rd_en, mem_wr_en, mem_addr}, 0);
        check_eq("midrst_rd_out", {clk150_dramRdData_valid, clk150_dramRdData_data}, 0);
        repeat (2) @(negedge clk150);
        clk150_cmd_dramWrData_valid = 1'b0;
        clk150_dramRdData_ready     = 1'b1;
        nReset150                   = 1'b1;
        repeat (2) @(negedge clk150);
        clear_logs();
        xfer("post_rst_accept", 1, {13'd8, 32'h40});
        wait_out("post_rst_done", 2, 100);
        repeat (10) @(negedge clk150);
        check_eq("post_rst_words", oq.size(), 2);
        check_eq("post_rst_reqs", rq_a.size(), 2);
        if (oq.size() >= 2) begin
            check_eq("post_rst_data0", oq[0], 32'h8000_0010);
            check_eq("post_rst_data1", oq[1], 32'h8000_0011);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/ssd_mem_cmd_responder.md
Name: ssd_mem_cmd_responder

Overview:
- Terminal responder on the clk150 side of the memcached-to-SSD/DRAM crossing.
- Consumes the 45-bit read and write command streams, the 32-bit write-data stream and a simple word-addressed memory port.
- Produces the 32-bit read-data stream that returns through the asynchronous FIFOs to clk156.
- Arbitrates read and write commands and splits each command into per-word memory accesses, with credit-based read-return buffering.

Parameters:
- LEN_W, 13, byte-length field width; command bits [44:32].
- ADDR_W, 32, byte-address field width; command bits [31:0].
- RD_FIFO_DEPTH, 16, read-return buffer entries; power of 2, at least 4.
- MEM_AW, 30, memory word-address width, equal to ADDR_W-2.

Ports:
- clk150  in  1  sole clock.
- nReset150  in  1  asynchronous, active-low reset.
- clk150_cmd_dramWrData_data  in  45  write command: {len[12:0], byte_addr[31:0]}.
- clk150_cmd_dramWrData_valid  in  1  write command valid.
- clk150_cmd_dramWrData_ready  out  1  write command accepted.
- clk150_cmd_dramRdData_data  in  45  read command: same format as write command.
- clk150_cmd_dramRdData_valid  in  1  read command valid.
- clk150_cmd_dramRdData_ready  out  1  read command accepted.
- clk150_dramWrData_data  in  32  write-data beat.
- clk150_dramWrData_valid  in  1  write-data valid.
- clk150_dramWrData_ready  out  1  write-data accepted.
- clk150_dramRdData_data  out  32  read-data beat.
- clk150_dramRdData_valid  out  1  read-data valid.
- clk150_dramRdData_ready  in  1  downstream accepts read data.
- mem_addr  out  MEM_AW  word address of the current access.
- mem_wr_en  out  1  write request.
- mem_wdata  out  32  write data.
- mem_rd_en  out  1  read request.
- mem_ready  in  1  memory accepts the request this cycle.
- mem_rdata  in  32  read return data; in order, latency 1 or more cycles.
- mem_rdata_valid  in  1  read return valid.

Behaviour:
- Reset: clock clk150; reset nReset150 is asynchronous, active-low. All outputs 0, FSM in IDLE, read buffer empty, outstanding count 0.
- Handshakes: valid/ready; a transfer occurs when both are high at a rising edge.
- Beat count: beats = (len + 3) >> 2, 12-bit result. Start word address = byte_addr[31:2]; byte_addr[1:0] ignored.
- FSM states: IDLE, WR_BURST, RD_BURST.
- IDLE, command select:
  - Both commands valid: round-robin, the type not served last wins; last-served resets to READ, so write wins first.
  - Command ready is combinational and asserted only for the granted command while in IDLE.
  - On accept: latch address and beats.
  - beats == 0: stay in IDLE; the command is consumed with no memory access.
  - Otherwise: write goes to WR_BURST, read goes to RD_BURST.
- WR_BURST:
  - clk150_dramWrData_ready = mem_ready.
  - mem_wr_en = clk150_dramWrData_valid; mem_wdata = clk150_dramWrData_data.
  - On a beat where both valid and mem_ready: address +1, remaining -1.
  - Return to IDLE after the beat where remaining reaches 0.
- RD_BURST:
  - credit = (buffer occupancy + outstanding) < RD_FIFO_DEPTH.
  - mem_rd_en = credit.
  - On mem_rd_en & mem_ready: address +1, remaining -1, outstanding +1.
  - IDLE after the last request is issued; returns may still be in flight and a new command may start.
- Read return:
  - mem_rdata_valid pushes into the buffer and decrements outstanding; a simultaneous issue and return leaves outstanding unchanged.
  - The buffer never overflows (guaranteed by credit); a push while full is an assertion failure.
  - clk150_dramRdData_valid = buffer not empty; pop on valid & ready.
  - Data is presented first-word-fall-through.
- Address wrap: wraps modulo 2^MEM_AW silently.
- Write data with no active write command is not accepted (ready = 0).
- Reset mid-burst: immediately returns to IDLE, flushes the buffer, zeroes outstanding. Late returns from memory after reset are the memory's responsibility and must be reset with it.

Decomposition:
- Package ssd_mem_pkg:
  - CMD_W = 45, LEN_W, ADDR_W.
  - Command field slice functions.
  - FSM state enum.
  - beats_f(len) function.
- Sub-module ssd_rd_fifo:
  - Synchronous FWFT FIFO, 32-bit wide, RD_FIFO_DEPTH entries.
  - Provides full, empty and count outputs.

Test Plan:
- Write command {len=16, addr=0x100}, data 0xA0..0xA3, mem_ready=1 → 4 mem_wr_en beats at mem_addr 0x40..0x43 with matching data; back to IDLE; cmd ready again the next cycle.
- Read command {len=6, addr=0x200}, memory latency 3 → 2 reads at 0x80 and 0x81; read data out in order.
- Read command len=256 (64 beats), clk150_dramRdData_ready=0 → exactly 16 mem_rd_en issued, then stall; releasing ready drains all 64 words in order, with no loss or duplication.
- Read and write commands valid every cycle → grants alternate W, R, W, R starting with write.
- Command with len=0 → consumed in 1 cycle; no mem access.
- Random mem_ready/ready toggling, then nReset150 pulled low mid RD_BURST → all outputs 0 during reset, buffer empty, and a following read completes correctly.
